regfile_write_scheduler: RTL
============================

Name: regfile_write_scheduler

Overview:
- Upstream stage of the 16-way register-write demultiplexer; produces its DemuxIn, Enable and Sel inputs, plus the write data bus that travels alongside them.
- Accepts write-back requests from the execute/load path over a valid/ready handshake and buffers them in a small FIFO.
- Issues buffered writes one per cycle as single-cycle strobes, stalling while the register file port is busy.
- Discards writes to the hardwired-zero register.

Parameters:
- DataWidth, 16, width of register write data.
- Depth, 4, FIFO entries; power of two, minimum 2.
- DropReg0, 1, when 1 a request to register 0 is accepted but never issued.

Ports:
- Clock  in  1  single system clock, rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- WbValid  in  1  upstream request valid.
- WbReady  out  1  scheduler can accept a request this cycle.
- WbReg  in  4  destination register index.
- WbData  in  DataWidth  write data.
- RfBusy  in  1  register file write port unavailable this cycle.
- Flush  in  1  synchronous discard of all queued, not-yet-issued writes.
- DemuxIn  out  1  write strobe; drives the demultiplexer data input.
- Enable  out  1  demultiplexer enable.
- Sel  out  4  demultiplexer select (register index).
- WrData  out  DataWidth  data accompanying the strobe.
- Count  out  clog2(Depth)+1  current FIFO occupancy.
- Empty  out  1  FIFO empty and no strobe in flight.

Behaviour:
- Reset (Reset_n=0, asynchronous): FIFO pointers and Count cleared; DemuxIn=0, Enable=0, Sel=0, WrData=0; WbReady=0 while in reset; Empty=1.
- Handshake:
  - WbReady = (Count < Depth) && !Flush. This is combinational from registered state and Flush only, never from WbValid.
  - Transfer occurs when WbValid && WbReady at a rising edge.
  - When full, WbReady stays 0 even if an entry pops in the same cycle (no full-pass-through).
- Drop rule: when DropReg0=1 and WbReg==0, the transfer completes but nothing is pushed.
- Issue logic: at each edge, with outputs registered:
  - If !RfBusy and an entry is available, load that entry into Sel/WrData and set Enable=1, DemuxIn=1 for exactly one cycle. Otherwise Enable=0, DemuxIn=0, and Sel/WrData hold their last value.
  - "Entry available" means the FIFO head, or (bypass) the request transferring at this edge when the FIFO is empty.
  - Latency: accepted at edge N, strobe visible during cycle N+1 when RfBusy=0 and the FIFO is empty.
- Ordering: strictly FIFO; at most one strobe per cycle.
- FSM, states IDLE / ISSUE / HOLD:
  - IDLE: Count=0, no strobe. A transfer with RfBusy=0 goes to ISSUE; with RfBusy=1 it goes to HOLD.
  - ISSUE: strobe asserted this cycle. Stay in ISSUE while entries remain and RfBusy=0. Go to HOLD if entries remain and RfBusy=1. Go to IDLE when none remain.
  - HOLD: entries queued, RfBusy=1, no strobe. Go to ISSUE when RfBusy falls.
- Simultaneous push and pop: Count unchanged; head advances, tail advances.
- Pointers wrap modulo Depth; Count distinguishes full from empty.
- Flush (synchronous):
  - Next edge: Count=0, pointers reset, state IDLE, no strobe next cycle.
  - A strobe already on the outputs during the Flush cycle completes; it is not retracted.
  - No request is accepted in the Flush cycle.
  - Flush has priority over RfBusy and WbValid.
- Reset mid-operation: all queued writes are lost and outputs are forced to 0 immediately (asynchronous).
- Empty = (Count==0) && !Enable.

Decomposition:
- Shared package constants: register index width (4), zero-register index (0), FSM state encoding (IDLE=2'b00, ISSUE=2'b01, HOLD=2'b10).
- One sub-module: regfile_write_fifo, a synchronous Depth × (4+DataWidth) FIFO with push, pop, flush and count. The scheduler holds the FSM, bypass path, drop rule and output registers.

Test Plan:
- Single write, idle:
  - Stimulus: WbValid=1, WbReg=5, WbData=16'hBEEF for one cycle, RfBusy=0.
  - Response: next cycle Enable=1, DemuxIn=1, Sel=5, WrData=BEEF for exactly 1 cycle; then Empty=1.
- Fill to full under stall:
  - Stimulus: RfBusy=1, push regs 1,2,3,4.
  - Response: Count=4, WbReady=0, no strobes. Release RfBusy: strobes on Sel 1,2,3,4 in 4 consecutive cycles; WbReady returns to 1 after the first pop.
- Zero-register drop:
  - Stimulus: push reg 0 then reg 7 back-to-back, RfBusy=0.
  - Response: both handshakes complete; only one strobe, Sel=7. With DropReg0=0, two strobes, Sel=0 then Sel=7.
- Stall mid-stream:
  - Stimulus: 3 queued writes; RfBusy=1 for 2 cycles after the first strobe.
  - Response: strobe, 2 idle cycles in HOLD, then 2 strobes in order.
- Flush:
  - Stimulus: queue regs 9,10,11, then assert Flush during the strobe for reg 9.
  - Response: strobe for 9 completes; no strobes for 10/11; Count=0; WbReady=0 during the Flush cycle.
- Async reset:
  - Stimulus: Reset_n dropped mid-cycle while Count=3 and Enable=1.
  - Response: Enable, DemuxIn, Sel, Count all 0 immediately, before the next edge; after release, behaviour matches fresh reset.

Source files
------------

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants and FSM encoding for the register-file write scheduler.
package regfile_write_scheduler_pkg;

    localparam int unsigned RegIdxW = 4;
    localparam logic [RegIdxW-1:0] ZeroReg = RegIdxW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/regfile_write_fifo.sv
// Depth-entry synchronous FIFO of {register index, data} write requests.
module regfile_write_fifo #(
    parameter int unsigned Width = 20,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [Width-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [Width-1:0]       head_data,
    output logic [$clog2(Depth):0] count
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CountW = PtrW + 1;

    logic [Width-1:0]  mem_q [Depth];
    logic [Width-1:0]  mem_d [Depth];
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CountW-1:0] count_q, count_d;

    // Pointers wrap naturally because Depth is a power of two.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PtrW'(1);
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            count_d = count_q + CountW'(push) - CountW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Buffers write-back requests and issues them as single-cycle strobes to the
// 16-way register-write demultiplexer, with empty-FIFO bypass and r0 drop.
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned Depth     = 4,
    parameter int unsigned DropReg0  = 1
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   WbValid,
    output logic                   WbReady,
    input  logic [RegIdxW-1:0]     WbReg,
    input  logic [DataWidth-1:0]   WbData,
    input  logic                   RfBusy,
    input  logic                   Flush,
    output logic                   DemuxIn,
    output logic                   Enable,
    output logic [RegIdxW-1:0]     Sel,
    output logic [DataWidth-1:0]   WrData,
    output logic [$clog2(Depth):0] Count,
    output logic                   Empty
);

    localparam int unsigned CountW = $clog2(Depth) + 1;
    localparam int unsigned EntryW = RegIdxW + DataWidth;

    state_e               state_q, state_d;
    logic                 strobe_q, strobe_d;
    logic [RegIdxW-1:0]   sel_q, sel_d;
    logic [DataWidth-1:0] wr_data_q, wr_data_d;

    logic                 fifo_push, fifo_pop;
    logic [EntryW-1:0]    fifo_head;
    logic [CountW-1:0]    fifo_count;
    logic                 fifo_empty, fifo_full;
    logic                 transfer, drop, accept, remaining;

    regfile_write_fifo #(
        .Width (EntryW),
        .Depth (Depth)
    ) u_fifo (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .push      (fifo_push),
        .push_data ({WbReg, WbData}),
        .pop       (fifo_pop),
        .flush     (Flush),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CountW'(Depth));

    // Ready never looks at WbValid; a pop while full does not open a slot.
    assign WbReady  = Reset_n && !fifo_full && !Flush;
    assign transfer = WbValid && WbReady;
    assign drop     = (DropReg0 != 0) && (WbReg == ZeroReg);
    assign accept   = transfer && !drop;

    always_comb begin
        state_d   = state_q;
        strobe_d  = 1'b0;
        sel_d     = sel_q;
        wr_data_d = wr_data_q;
        fifo_push = accept;
        fifo_pop  = 1'b0;
        remaining = 1'b0;

        if (Flush) begin
            state_d   = ST_IDLE;
            fifo_push = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && !RfBusy) begin
                        strobe_d  = 1'b1;
                        sel_d     = WbReg;
                        wr_data_d = WbData;
                        fifo_push = 1'b0;
                    end
                end
                ST_ISSUE, ST_HOLD: begin
                    if (!RfBusy) begin
                        if (!fifo_empty) begin
                            strobe_d  = 1'b1;
                            fifo_pop  = 1'b1;
                            sel_d     = fifo_head[EntryW-1 -: RegIdxW];
                            wr_data_d = fifo_head[DataWidth-1:0];
                        end else if (accept) begin
                            strobe_d  = 1'b1;
                            sel_d     = WbReg;
                            wr_data_d = WbData;
                            fifo_push = 1'b0;
                        end
                    end
                end
                default: ;
            endcase

            // Entries left in the FIFO after this edge decide HOLD versus IDLE.
            remaining = fifo_push || (fifo_count > CountW'(fifo_pop));
            if (strobe_d) begin
                state_d = ST_ISSUE;
            end else if (remaining) begin
                state_d = ST_HOLD;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            strobe_q  <= 1'b0;
            sel_q     <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            strobe_q  <= strobe_d;
            sel_q     <= sel_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign DemuxIn = strobe_q;
    assign Enable  = strobe_q;
    assign Sel     = sel_q;
    assign WrData  = wr_data_q;
    assign Count   = fifo_count;
    assign Empty   = fifo_empty && !strobe_q;

endmodule
